// File: rtl/dis_scroll_layer_if.sv
// Coordinate/pixel bus between the paint-coordinate generator and a bitmap layer.
// master = coordinate source / compositor side, slave = layer renderer.
interface dis_scroll_layer_if;
  logic signed [15:0] paint_x;
  logic signed [15:0] paint_y;
  logic               frame_start;
  logic               scroll_en;
  logic [7:0]         scroll_step;
  logic               paint_enable;
  logic [15:0]        paint_color;

  modport master (
    output paint_x, paint_y, frame_start, scroll_en, scroll_step,
    input  paint_enable, paint_color
  );
  modport slave (
    input  paint_x, paint_y, frame_start, scroll_en, scroll_step,
    output paint_enable, paint_color
  );
endinterface

// File: rtl/dis_scroll_layer.sv
// Scrolling, y-tiled, palette-indexed bitmap layer with a transparent index.
// Fixed 5-cycle latency from paint coordinate to paint_enable/paint_color.

// 1-cycle synchronous ROM. Contents are generated procedurally:
// KIND 0 folds the address into a DW-bit index, KIND 1 is a palette pattern.
module dis_scroll_rom #(
  parameter int AW   = 13,
  parameter int DW   = 4,
  parameter int KIND = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] o_data
);
  function automatic logic [DW-1:0] content(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    d = '0;
    if (KIND == 0) begin
      for (int i = 0; i < AW; i++) d[i % DW] = d[i % DW] ^ a[i];
    end else begin
      for (int b = 0; b < DW; b++) d[b] = a[b % AW] ^ (((b / AW) % 2) == 1);
    end
    return d;
  endfunction

  logic [DW-1:0] r_data;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_data <= '0;
    else       r_data <= content(i_addr);
  end
  assign o_data = r_data;
endmodule

module dis_scroll_layer #(
  parameter int POS_X           = 192,
  parameter int POS_Y           = 0,
  parameter int BMP_W           = 40,
  parameter int BMP_H           = 120,
  parameter int SCALE_SHIFT     = 2,
  parameter int VIEW_H          = 480,
  parameter int IDX_W           = 4,
  parameter int ADDR_W          = 13,
  parameter int TRANSPARENT_IDX = 0
) (
  input logic              clk,
  input logic              rstn,
  dis_scroll_layer_if.slave bus
);
  localparam int SPAN = BMP_H << SCALE_SHIFT;
  localparam logic signed [17:0] L_POSX = 18'(POS_X);
  localparam logic signed [17:0] L_POSY = 18'(POS_Y);
  localparam logic signed [17:0] L_SPAN = 18'(SPAN);
  localparam logic signed [17:0] L_WINW = 18'(BMP_W << SCALE_SHIFT);
  localparam logic signed [17:0] L_VIEW = 18'(VIEW_H);
  localparam logic [16:0]        L_SPAN17 = 17'(SPAN);

  // scroll position, advanced only on frame_start
  logic [15:0] r_scroll_pos;
  logic [16:0] w_sum;
  assign w_sum = {1'b0, r_scroll_pos} + {9'b0, bus.scroll_step};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_scroll_pos <= '0;
    else if (bus.frame_start && bus.scroll_en)
      r_scroll_pos <= (w_sum >= L_SPAN17) ? 16'(w_sum - L_SPAN17) : w_sum[15:0];
  end

  // S1: window test and wrapped y
  logic signed [17:0] w_sx, w_ry, w_t;
  logic        [15:0] w_sy;
  logic               w_act;
  always_comb begin
    w_sx  = {{2{bus.paint_x[15]}}, bus.paint_x} - L_POSX;
    w_ry  = {{2{bus.paint_y[15]}}, bus.paint_y} - L_POSY;
    w_t   = w_ry + $signed({2'b00, r_scroll_pos});
    w_sy  = (w_t >= L_SPAN) ? 16'(w_t - L_SPAN) : w_t[15:0];
    w_act = !w_sx[17] && (w_sx < L_WINW) && !w_ry[17] && (w_ry < L_VIEW);
  end

  logic signed [15:0] r_sx, r_sy;
  logic [ADDR_W-1:0]  r_addr;
  logic [3:0]         r_vld_pipe;   // act for stages 1..4
  logic [IDX_W-1:0]   w_idx, r_idx4;
  logic [15:0]        w_pal;
  logic               w_opq;
  logic               r_en;
  logic [15:0]        r_col;

  // S2: texel address (row-major, BMP_W texels per row)
  logic [ADDR_W-1:0] w_addr;
  assign w_addr = ADDR_W'(r_sx >>> SCALE_SHIFT)
                + ADDR_W'(r_sy >>> SCALE_SHIFT) * ADDR_W'(BMP_W);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sx       <= '0;
      r_sy       <= '0;
      r_addr     <= '0;
      r_vld_pipe <= '0;
      r_idx4     <= '0;
      r_en       <= 1'b0;
      r_col      <= '0;
    end else begin
      r_sx       <= w_sx[15:0];
      r_sy       <= $signed(w_sy);
      r_addr     <= w_addr;
      r_vld_pipe <= {r_vld_pipe[2:0], w_act};
      r_idx4     <= w_idx;
      r_en       <= w_opq;
      r_col      <= w_opq ? w_pal : 16'h0000;
    end
  end

  // S3 image ROM, S4 palette ROM
  dis_scroll_rom #(.AW(ADDR_W), .DW(IDX_W), .KIND(0)) u_img (
    .clk(clk), .rstn(rstn), .i_addr(r_addr), .o_data(w_idx)
  );
  dis_scroll_rom #(.AW(IDX_W), .DW(16), .KIND(1)) u_pal (
    .clk(clk), .rstn(rstn), .i_addr(w_idx), .o_data(w_pal)
  );

  assign w_opq = r_vld_pipe[3] && (r_idx4 != IDX_W'(TRANSPARENT_IDX));

  assign bus.paint_enable = r_en;
  assign bus.paint_color  = r_col;
endmodule
